bin_to_bcd_serial: RTL and testbench

- Sequential double-dabble (shift-and-add-3) converter: unsigned binary in, packed BCD digits out.
- Sits directly upstream of the multiplexed seven-segment driver. Its `bcd` output connects straight to the driver's 4-bits-per-digit `value` bus, with digit 0 in the least-significant nibble.
- Converts one bit per clock using a valid/ready input handshake and a one-cycle `done` pulse. The output is held stable between conversions so the display never shows partial results.

---
 rtl/bin_to_bcd_serial_pkg.sv | 46 ++++
 rtl/bin_to_bcd_serial_add3.sv | 23 ++
 rtl/bin_to_bcd_serial.sv | 160 ++++++++++++++++
 tb/tb_bin_to_bcd_serial.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_serial_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_serial_pkg
// Shared definitions for the serial double-dabble binary-to-BCD converter:
//   - BCD_DIGIT_W : width of one packed BCD digit
//   - state_t     : converter FSM encoding (IDLE / SHIFT / DONE)
//   - clog2       : ceiling log2, used to size the bit counter
//   - pow10       : 10^n, used for the saturation limit when
//                   BIN_TO_BCD_OVERFLOW_SAT_EN is defined
// -----------------------------------------------------------------------------
package bin_to_bcd_serial_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    longint unsigned span;
    result = 0;
    span   = 1;
    for (int i = 0; i < 64; i++) begin
      if (span < longint'(value)) begin
        result = i + 1;
        span   = span << 1;
      end
    end
    return result;
  endfunction

  // 10^n in 64 bits; enough headroom to hold the limit for any digit count
  // that a 32-bit input can actually reach.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3_digit
// Combinational double-dabble correction for a single BCD digit: adds 3 when
// the digit is 5 or more, so the following left shift carries correctly into
// the next decade.
//   digit_i : current 4-bit scratch digit
//   digit_o : corrected digit (digit_i + 3 if digit_i >= 5, else digit_i)
// -----------------------------------------------------------------------------
module bcd_add3_digit
  import bin_to_bcd_serial_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_serial
// Sequential double-dabble converter, one input bit per clock. Feeds the
// seven-segment driver's value bus directly (digit 0 in the low nibble).
//
// Parameters:
//   IN_WIDTH : binary input width (1..32)
//   DIGITS   : number of BCD digits produced
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   in_data  : unsigned binary value, sampled when in_valid && in_ready
//   in_valid : in_data is valid
//   in_ready : converter idle, will accept in_data
//   bcd      : packed BCD result, digit k in bcd[4k+3:4k]; held between
//              conversions
//   done     : one-cycle pulse, bcd was updated on this edge
//   overflow : only with BIN_TO_BCD_OVERFLOW_SAT_EN; input exceeded
//              10^DIGITS-1 and bcd was saturated to all nines
//
// Build option: define BIN_TO_BCD_OVERFLOW_SAT_EN to saturate instead of
// wrapping modulo 10^DIGITS.
// -----------------------------------------------------------------------------
module bin_to_bcd_serial
  import bin_to_bcd_serial_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int DIGITS   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          done
`ifdef BIN_TO_BCD_OVERFLOW_SAT_EN
  ,
  output logic                          overflow
`endif
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (IN_WIDTH > 1) ? clog2(IN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_WIDTH - 1);

  state_t               state_q,   state_d;
  logic [IN_WIDTH-1:0]  shift_q,   shift_d;
  logic [SCR_W-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [SCR_W-1:0]     bcd_q,     bcd_d;
  logic                 done_q,    done_d;
  logic [SCR_W-1:0]     scratch_adj;

`ifdef BIN_TO_BCD_OVERFLOW_SAT_EN
  localparam logic [63:0] SAT_LIMIT = pow10(DIGITS) - 64'd1;
  localparam logic [SCR_W-1:0] ALL_NINES = {DIGITS{4'd9}};

  // Decision is taken at capture time so the shift register can be consumed
  // freely during SHIFT.
  logic ovf_pend_q, ovf_pend_d;
  logic ovf_q,      ovf_d;
`endif

  // Per-digit add-3 correction applied before every shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_i (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
`ifdef BIN_TO_BCD_OVERFLOW_SAT_EN
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_d   = in_data;
          scratch_d = '0;
          cnt_d     = CNT_LOAD;
          state_d   = ST_SHIFT;
`ifdef BIN_TO_BCD_OVERFLOW_SAT_EN
          ovf_pend_d = (64'(in_data) > SAT_LIMIT);
`endif
        end
      end

      ST_SHIFT: begin
        // {scratch, shift} <<= 1; anything leaving the top digit is dropped,
        // which is what gives the modulo-10^DIGITS result.
        scratch_d = {scratch_adj[SCR_W-2:0], shift_q[IN_WIDTH-1]};
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef BIN_TO_BCD_OVERFLOW_SAT_EN
        ovf_d = ovf_pend_q;
        if (ovf_pend_q) begin
          bcd_d = ALL_NINES;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
`ifdef BIN_TO_BCD_OVERFLOW_SAT_EN
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
`ifdef BIN_TO_BCD_OVERFLOW_SAT_EN
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign bcd      = bcd_q;
  assign done     = done_q;
`ifdef BIN_TO_BCD_OVERFLOW_SAT_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_serial
// Directed-vector bench for bin_to_bcd_serial (IN_WIDTH=10, DIGITS=3).
// Stimulus pushes hand-computed expected results into a queue; a monitor pops
// and compares on every done pulse. Works with or without
// BIN_TO_BCD_OVERFLOW_SAT_EN.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_serial;

  localparam int IN_WIDTH = 10;
  localparam int DIGITS   = 3;

  typedef struct packed {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [IN_WIDTH-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [11:0]         bcd;
  logic                done;
  logic                ovf_w;

  bin_to_bcd_serial #(
    .IN_WIDTH (IN_WIDTH),
    .DIGITS   (DIGITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd      (bcd),
    .done     (done)
`ifdef BIN_TO_BCD_OVERFLOW_SAT_EN
    ,
    .overflow (ovf_w)
`endif
  );

`ifndef BIN_TO_BCD_OVERFLOW_SAT_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cycle = 0;
  int   done_cnt = 0;
  int   last_done_cycle = 0;
  int   prev_done_cycle = 0;
  int   target = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor / scoreboard: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_cnt        = done_cnt + 1;
      prev_done_cycle = last_done_cycle;
      last_done_cycle = cycle;
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_done: bcd=%03h ovf=%0b with nothing expected", bcd, ovf_w);
      end else begin
        e = exp_q.pop_front();
        if (bcd !== e.bcd || ovf_w !== e.ovf) begin
          n_err = n_err + 1;
          $display("FAIL result: got bcd=%03h ovf=%0b, expected bcd=%03h ovf=%0b",
                   bcd, ovf_w, e.bcd, e.ovf);
        end else begin
          $display("done @%0d: bcd=%03h ovf=%0b ok", cycle, bcd, ovf_w);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [11:0] b, input logic o);
    exp_t e;
    e.bcd = b;
    e.ovf = o;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next falling edge: inputs change and direct
  // checks happen well away from the rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_WIDTH-1:0] v, input exp_t e);
    int t;
    t = 0;
    while (!in_ready && t < 40) begin
      step();
      t++;
    end
    check("ready_timeout", 32'(in_ready), 32'd1);
    in_data  = v;
    in_valid = 1'b1;
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int want);
    int t;
    t = 0;
    while (done_cnt < want && t < 40) begin
      step();
      t++;
    end
    check("done_timeout", 32'(done_cnt >= want), 32'd1);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("reset_bcd", 32'(bcd), 32'h000);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);

    // Basic conversion with latency / busy-window check
    in_data  = 10'd255;
    in_valid = 1'b1;
    exp_q.push_back(mk(12'h255, 1'b0));
    step();
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin
      n++;
      step();
    end
    check("busy_cycles", 32'(n), 32'd11);
    check("done_with_ready", 32'(done), 32'd1);
    target = target + 1;
    wait_done(target);

    // Boundaries
    send(10'd0,   mk(12'h000, 1'b0)); target++; wait_done(target);
    send(10'd9,   mk(12'h009, 1'b0)); target++; wait_done(target);
    send(10'd10,  mk(12'h010, 1'b0)); target++; wait_done(target);
    send(10'd999, mk(12'h999, 1'b0)); target++; wait_done(target);

    // Overflow / modulo
`ifdef BIN_TO_BCD_OVERFLOW_SAT_EN
    send(10'd1023, mk(12'h999, 1'b1)); target++; wait_done(target);
`else
    send(10'd1023, mk(12'h023, 1'b0)); target++; wait_done(target);
`endif
    send(10'd5, mk(12'h005, 1'b0)); target++; wait_done(target);

    // Busy ignore, then back-to-back with in_valid held high
    step();
    in_data  = 10'd123;
    in_valid = 1'b1;
    exp_q.push_back(mk(12'h123, 1'b0));
    exp_q.push_back(mk(12'h456, 1'b0));
    step();
    in_data = 10'd456;
    target++;
    wait_done(target);
    step();
    in_valid = 1'b0;
    target++;
    wait_done(target);
    check("back_to_back_spacing", 32'(last_done_cycle - prev_done_cycle), 32'd12);

    // Reset mid-conversion: no expectation pushed, so any done is flagged
    step();
    in_data  = 10'd777;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_bcd", 32'(bcd), 32'h000);
    check("async_reset_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    repeat (15) step();
    check("no_done_after_abort", 32'(done_cnt), 32'(target));
    check("idle_after_abort", 32'(in_ready), 32'd1);

    send(10'd42, mk(12'h042, 1'b0)); target++; wait_done(target);
    repeat (3) step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
